core_hcu_sb: RTL and testbench
==============================

// Module: core_hcu_sb
// PURPOSE
//   Parametrised hazard control unit for an N-stage RV32I pipeline.
//   Keeps its own destination-register scoreboard per pipeline register.
//   Produces per-register write/flush enables, PC write, forwarding selects and memory-wait stalls.
//   Sits beside the pipeline registers and replaces per-stage hazard comparator inputs.
// PARAMETERS
//   NSTAGES   5      pipeline stages; P=NSTAGES-1 pipeline regs R0=IF/ID, R1=ID/EX, ... R(P-1)
//   BR_STAGE  2      redirect resolved while branch sits in R(BR_STAGE-1); 1<=BR_STAGE<=P-1
//   FWD_EN    1      1: forwarding, stall on load-use only; 0: stall on any pending write
//   TIMEOUT   1023   DMEM wait cycles before HCU_TIMEOUT sets
//   FW        $clog2(NSTAGES)  forwarding select width (derived)
// PORTS
//   CLK              in   1    clock, rising edge
//   RST              in   1    asynchronous reset, active-high
//   ID_VALID         in   1    ID holds a real instruction
//   ID_RS1/ID_RS2    in   5    source register indices in ID
//   ID_RS1_USE/RS2   in   1    source actually read
//   ID_RD            in   5    destination index in ID
//   ID_RD_VALID      in   1    instruction writes rd
//   ID_ISLOAD        in   1    instruction in ID is a load
//   REDIRECT         in   1    taken branch / JAL / JALR from R(BR_STAGE-1)
//   IMEM_BUSY        in   1    fetch not ready
//   DMEM_REQ         in   1    MEM stage issues load/store
//   DMEM_DONE        in   1    data memory access complete
//   HCU_PC_WRITE     out  1    PC update enable
//   HCU_STAGE_WRITE  out  P    bit k = write enable of Rk
//   HCU_STAGE_FLUSH  out  P    bit k = load bubble into Rk (wins over write)
//   HCU_FWD_RS1/RS2  out  FW   0=regfile, k=forward from Rk
//   HCU_TIMEOUT      out  1    sticky DMEM timeout flag
//   HCU_STALL_CNT    out  16   saturating count of cycles with HCU_PC_WRITE=0
// BEHAVIOUR
//   Reset (async): scoreboard cleared, FSM IDLE, counters 0, TIMEOUT 0; while RST high:
//     PC_WRITE=0, STAGE_WRITE=0, STAGE_FLUSH=all 1, FWD=0.
//   Scoreboard sb[k], k=1..P-1 = {valid,rd,isload}; on CLK: flush[k] -> 0; else write[k] ->
//     sb[k-1] (sb[1] <- {ID_VALID&ID_RD_VALID&rd!=0, ID_RD, ID_ISLOAD}); else hold.
//   Match(rs,k): rs!=0, use bit set, sb[k].valid, sb[k].rd==rs.
//   Data hazard: FWD_EN=1: Match(rs,1)&sb[1].isload. FWD_EN=0: Match(rs,k) any k in 1..P-2
//     (regfile write-through covers R(P-1)).
//   Forward (FWD_EN=1): smallest k in 1..P-1 with Match, excluding k=1 load; else 0. FWD_EN=0: always 0.
//   DMEM FSM: IDLE: DMEM_REQ & !DMEM_DONE -> WAIT. WAIT: DMEM_DONE -> IDLE. Stall = (IDLE&DMEM_REQ&!DONE)|(WAIT&!DONE).
//   Timeout counter: counts WAIT cycles, clears in IDLE; reaching TIMEOUT sets HCU_TIMEOUT (sticky until RST); FSM stays in WAIT.
//   Priority, combinational per cycle (defaults: all writes 1, flushes 0):
//     1 dmem stall: PC_WRITE=0, all STAGE_WRITE=0, no flush.
//     2 REDIRECT: PC_WRITE=1; flush R0..R(BR_STAGE-1); branch advances into R(BR_STAGE).
//     3 data hazard: PC_WRITE=0, R0 write=0, R1 flush=1 (bubble); downstream advances.
//     4 IMEM_BUSY: PC_WRITE=0, R0 flush=1; downstream advances.
//     Data hazard and IMEM_BUSY together: rule 3 applies.
//   DMEM_DONE cycle: stall released, all registers write that cycle.
//   Stall counter: +1 on each post-reset cycle with PC_WRITE=0; saturates at 16'hFFFF.
// TESTING
//   lw x5 in R1, ID add uses x5, FWD_EN=1 -> 1 cycle: PC_WRITE=0, FLUSH[1]=1; next cycle FWD_RS1=2.
//   add x5 in R1, ID uses x5, FWD_EN=1 -> no stall, FWD_RS1=1; FWD_EN=0 -> stall until x5 in R(P-1).
//   ID rs1=x0 matching sb rd=x0 load -> no stall, FWD_RS1=0.
//   DMEM_REQ, DONE after 3 cycles -> 3 cycles all writes 0, 4th cycle all 1; STALL_CNT=3.
//   REDIRECT with DMEM stall same cycle -> freeze wins; REDIRECT alone -> FLUSH=2'b11 (R0,R1), PC_WRITE=1.
//   TIMEOUT=4, DONE never -> HCU_TIMEOUT=1 after 4 WAIT cycles; RST mid-wait -> flag 0, FSM IDLE.

Source files
------------

// File: rtl/core_hcu_sb_if.sv
// Hazard-control bundle between pipeline datapath (master) and hazard unit (slave).
interface core_hcu_sb_if #(
    parameter int NSTAGES = 5
);
    localparam int P  = NSTAGES - 1;
    localparam int FW = $clog2(NSTAGES);

    logic          id_valid;
    logic [4:0]    id_rs1;
    logic [4:0]    id_rs2;
    logic          id_rs1_use;
    logic          id_rs2_use;
    logic [4:0]    id_rd;
    logic          id_rd_valid;
    logic          id_isload;
    logic          redirect;
    logic          imem_busy;
    logic          dmem_req;
    logic          dmem_done;
    logic          hcu_pc_write;
    logic [P-1:0]  hcu_stage_write;
    logic [P-1:0]  hcu_stage_flush;
    logic [FW-1:0] hcu_fwd_rs1;
    logic [FW-1:0] hcu_fwd_rs2;
    logic          hcu_timeout;
    logic [15:0]   hcu_stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_use, id_rs2_use, id_rd, id_rd_valid,
               id_isload, redirect, imem_busy, dmem_req, dmem_done,
        input  hcu_pc_write, hcu_stage_write, hcu_stage_flush, hcu_fwd_rs1, hcu_fwd_rs2,
               hcu_timeout, hcu_stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_use, id_rs2_use, id_rd, id_rd_valid,
               id_isload, redirect, imem_busy, dmem_req, dmem_done,
        output hcu_pc_write, hcu_stage_write, hcu_stage_flush, hcu_fwd_rs1, hcu_fwd_rs2,
               hcu_timeout, hcu_stall_cnt
    );
endinterface

// File: rtl/core_hcu_sb.sv
// Hazard control unit with private destination scoreboard for an N-stage RV32I pipeline.
// state  | meaning
// S_IDLE | no data-memory access outstanding
// S_WAIT | access issued, waiting for DMEM_DONE (timeout counter running)
module core_hcu_sb #(
    parameter int NSTAGES  = 5,
    parameter int BR_STAGE = 2,
    parameter int FWD_EN   = 1,
    parameter int TIMEOUT  = 1023
) (
    input  logic          i_clk,
    input  logic          i_rst,
    core_hcu_sb_if.slave  if_hcu
);
    localparam int P  = NSTAGES - 1;
    localparam int FW = $clog2(NSTAGES);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {S_IDLE, S_WAIT} dmem_state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       isload;
    } sb_t;

    dmem_state_t   r_state;
    logic [TW-1:0] r_to_cnt;
    logic          r_timeout;
    logic [15:0]   r_stall_cnt;
    sb_t           r_sb    [1:P-1];
    sb_t           w_sb_in [1:P-1];

    logic          w_dmem_stall;
    logic          w_hazard;
    logic          w_pc_write;
    logic [P-1:0]  w_write;
    logic [P-1:0]  w_flush;
    logic [FW-1:0] w_fwd1;
    logic [FW-1:0] w_fwd2;

    function automatic logic f_match(input logic [4:0] rs, input logic use_b, input sb_t e);
        return (rs != 5'd0) && use_b && e.valid && (e.rd == rs);
    endfunction

    assign w_dmem_stall = !if_hcu.dmem_done &&
                          ((r_state == S_IDLE && if_hcu.dmem_req) || r_state == S_WAIT);

    always_comb begin
        w_hazard = 1'b0;
        if (FWD_EN != 0) begin
            w_hazard = (f_match(if_hcu.id_rs1, if_hcu.id_rs1_use, r_sb[1]) ||
                        f_match(if_hcu.id_rs2, if_hcu.id_rs2_use, r_sb[1])) && r_sb[1].isload;
        end else begin
            // last pipeline register is covered by regfile write-through
            for (int k = 1; k <= P-2; k++) begin
                if (f_match(if_hcu.id_rs1, if_hcu.id_rs1_use, r_sb[k]) ||
                    f_match(if_hcu.id_rs2, if_hcu.id_rs2_use, r_sb[k]))
                    w_hazard = 1'b1;
            end
        end
    end

    // descending scan so the youngest (smallest k) match wins
    always_comb begin
        w_fwd1 = '0;
        w_fwd2 = '0;
        if (FWD_EN != 0 && !i_rst) begin
            for (int k = P-1; k >= 1; k--) begin
                if (!(k == 1 && r_sb[1].isload)) begin
                    if (f_match(if_hcu.id_rs1, if_hcu.id_rs1_use, r_sb[k])) w_fwd1 = FW'(k);
                    if (f_match(if_hcu.id_rs2, if_hcu.id_rs2_use, r_sb[k])) w_fwd2 = FW'(k);
                end
            end
        end
    end

    always_comb begin
        w_pc_write = 1'b1;
        w_write    = '1;
        w_flush    = '0;
        if (i_rst) begin
            w_pc_write = 1'b0;
            w_write    = '0;
            w_flush    = '1;
        end else if (w_dmem_stall) begin
            w_pc_write = 1'b0;
            w_write    = '0;
        end else if (if_hcu.redirect) begin
            for (int k = 0; k < P; k++) begin
                if (k < BR_STAGE) w_flush[k] = 1'b1;
            end
        end else if (w_hazard) begin
            w_pc_write = 1'b0;
            w_write[0] = 1'b0;
            w_flush[1] = 1'b1;
        end else if (if_hcu.imem_busy) begin
            w_pc_write = 1'b0;
            w_flush[0] = 1'b1;
        end
    end

    always_comb begin
        w_sb_in[1] = {if_hcu.id_valid & if_hcu.id_rd_valid & (if_hcu.id_rd != 5'd0),
                      if_hcu.id_rd, if_hcu.id_isload};
        for (int k = 2; k <= P-1; k++) w_sb_in[k] = r_sb[k-1];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 1; k <= P-1; k++) r_sb[k] <= '0;
        end else begin
            for (int k = 1; k <= P-1; k++) begin
                if (w_flush[k])      r_sb[k] <= '0;
                else if (w_write[k]) r_sb[k] <= w_sb_in[k];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_to_cnt    <= '0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (!w_pc_write && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
            case (r_state)
                S_IDLE: begin
                    r_to_cnt <= '0;
                    if (if_hcu.dmem_req && !if_hcu.dmem_done) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (if_hcu.dmem_done) begin
                        r_state  <= S_IDLE;
                        r_to_cnt <= '0;
                    end else if (r_to_cnt != TW'(TIMEOUT)) begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                        if (r_to_cnt == TW'(TIMEOUT - 1)) r_timeout <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign if_hcu.hcu_pc_write    = w_pc_write;
    assign if_hcu.hcu_stage_write = w_write;
    assign if_hcu.hcu_stage_flush = w_flush;
    assign if_hcu.hcu_fwd_rs1     = w_fwd1;
    assign if_hcu.hcu_fwd_rs2     = w_fwd2;
    assign if_hcu.hcu_timeout     = r_timeout;
    assign if_hcu.hcu_stall_cnt   = r_stall_cnt;
endmodule

// File: tb/tb_core_hcu_sb.sv
// Directed bench: forwarding variant (short timeout) and stall-only variant side by side.
module tb_core_hcu_sb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    core_hcu_sb_if #(.NSTAGES(5)) if_a ();
    core_hcu_sb_if #(.NSTAGES(5)) if_b ();

    core_hcu_sb #(.NSTAGES(5), .BR_STAGE(2), .FWD_EN(1), .TIMEOUT(4)) u_a (
        .i_clk(clk), .i_rst(rst), .if_hcu(if_a.slave));
    core_hcu_sb #(.NSTAGES(5), .BR_STAGE(2), .FWD_EN(0), .TIMEOUT(1023)) u_b (
        .i_clk(clk), .i_rst(rst), .if_hcu(if_b.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                          input logic rdv, input logic ld);
        if_a.id_valid = v;  if_a.id_rs1 = rs1; if_a.id_rs1_use = u1; if_a.id_rs2 = rs2;
        if_a.id_rs2_use = u2; if_a.id_rd = rd; if_a.id_rd_valid = rdv; if_a.id_isload = ld;
        if_b.id_valid = v;  if_b.id_rs1 = rs1; if_b.id_rs1_use = u1; if_b.id_rs2 = rs2;
        if_b.id_rs2_use = u2; if_b.id_rd = rd; if_b.id_rd_valid = rdv; if_b.id_isload = ld;
    endtask

    task automatic set_ctl(input logic redir, input logic imem, input logic req, input logic done);
        if_a.redirect = redir; if_a.imem_busy = imem; if_a.dmem_req = req; if_a.dmem_done = done;
        if_b.redirect = redir; if_b.imem_busy = imem; if_b.dmem_req = req; if_b.dmem_done = done;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_ctl(0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_ctl(0, 0, 0, 0);
        @(negedge clk);
        chk("rst_pcw",   if_a.hcu_pc_write,    0);
        chk("rst_write", if_a.hcu_stage_write, 0);
        chk("rst_flush", if_a.hcu_stage_flush, 4'hF);
        chk("rst_fwd1",  if_a.hcu_fwd_rs1,     0);
        chk("rst_to",    if_a.hcu_timeout,     0);
        chk("rst_cnt",   if_a.hcu_stall_cnt,   0);

        // load-use: lw x5 then add x6,x5,x7 (IMEM_BUSY also raised, hazard has priority)
        do_reset();
        set_id(1, 0, 0, 0, 0, 5, 1, 1);
        @(negedge clk);
        chk("lu_c0_pcw",   if_a.hcu_pc_write,    1);
        chk("lu_c0_write", if_a.hcu_stage_write, 4'hF);
        tick();
        set_id(1, 5, 1, 7, 1, 6, 1, 0);
        set_ctl(0, 1, 0, 0);
        @(negedge clk);
        chk("lu_a_pcw",   if_a.hcu_pc_write,    0);
        chk("lu_a_flush", if_a.hcu_stage_flush, 4'b0010);
        chk("lu_a_write", if_a.hcu_stage_write, 4'b1110);
        chk("lu_b_flush", if_b.hcu_stage_flush, 4'b0010);
        tick();
        set_ctl(0, 0, 0, 0);
        @(negedge clk);
        chk("lu_a_pcw2",  if_a.hcu_pc_write, 1);
        chk("lu_a_fwd2",  if_a.hcu_fwd_rs1,  2);
        chk("lu_a_fwdb",  if_a.hcu_fwd_rs2,  0);
        chk("lu_b_pcw2",  if_b.hcu_pc_write, 0);
        tick();
        @(negedge clk);
        chk("lu_a_fwd3",  if_a.hcu_fwd_rs1,   3);
        chk("lu_b_pcw3",  if_b.hcu_pc_write,  1);
        chk("lu_b_fwd3",  if_b.hcu_fwd_rs1,   0);
        chk("lu_a_cnt",   if_a.hcu_stall_cnt, 1);
        chk("lu_b_cnt",   if_b.hcu_stall_cnt, 2);

        // ALU producer: forward from R1 with no stall, stall-only variant stalls
        do_reset();
        set_id(1, 0, 0, 0, 0, 5, 1, 0);
        tick();
        set_id(1, 5, 1, 0, 1, 6, 1, 0);
        @(negedge clk);
        chk("alu_a_pcw",  if_a.hcu_pc_write, 1);
        chk("alu_a_fwd1", if_a.hcu_fwd_rs1,  1);
        chk("alu_a_fwd2", if_a.hcu_fwd_rs2,  0);
        chk("alu_b_pcw",  if_b.hcu_pc_write, 0);

        // x0 never creates a hazard or forward
        do_reset();
        set_id(1, 0, 0, 0, 0, 0, 1, 1);
        tick();
        set_id(1, 0, 1, 0, 1, 7, 1, 0);
        @(negedge clk);
        chk("x0_pcw",   if_a.hcu_pc_write,    1);
        chk("x0_fwd1",  if_a.hcu_fwd_rs1,     0);
        chk("x0_flush", if_a.hcu_stage_flush, 0);

        // DMEM: done arrives on the 4th cycle
        do_reset();
        set_ctl(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("dm_write", if_a.hcu_stage_write, 0);
            chk("dm_pcw",   if_a.hcu_pc_write,    0);
            chk("dm_flush", if_a.hcu_stage_flush, 0);
            tick();
        end
        set_ctl(0, 0, 1, 1);
        @(negedge clk);
        chk("dm_done_write", if_a.hcu_stage_write, 4'hF);
        chk("dm_done_pcw",   if_a.hcu_pc_write,    1);
        tick();
        set_ctl(0, 0, 0, 0);
        @(negedge clk);
        chk("dm_cnt", if_a.hcu_stall_cnt, 3);

        // redirect vs. freeze, redirect alone, IMEM_BUSY alone
        do_reset();
        set_ctl(1, 0, 1, 0);
        @(negedge clk);
        chk("rd_frz_pcw",   if_a.hcu_pc_write,    0);
        chk("rd_frz_write", if_a.hcu_stage_write, 0);
        chk("rd_frz_flush", if_a.hcu_stage_flush, 0);
        tick();
        set_ctl(0, 0, 0, 1);
        @(negedge clk);
        chk("rd_rel_write", if_a.hcu_stage_write, 4'hF);
        tick();
        set_ctl(1, 0, 0, 0);
        @(negedge clk);
        chk("rd_flush", if_a.hcu_stage_flush, 4'b0011);
        chk("rd_pcw",   if_a.hcu_pc_write,    1);
        tick();
        set_ctl(0, 1, 0, 0);
        @(negedge clk);
        chk("im_pcw",   if_a.hcu_pc_write,    0);
        chk("im_flush", if_a.hcu_stage_flush, 4'b0001);
        chk("im_write", if_a.hcu_stage_write, 4'hF);

        // timeout after 4 WAIT cycles, then reset mid-wait
        do_reset();
        set_ctl(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) tick();
        @(negedge clk);
        chk("to_early", if_a.hcu_timeout, 0);
        tick();
        @(negedge clk);
        chk("to_set",   if_a.hcu_timeout,  1);
        chk("to_stall", if_a.hcu_pc_write, 0);
        tick();
        rst = 1'b1;
        #1;
        chk("to_rst_flag", if_a.hcu_timeout, 0);
        tick();
        rst = 1'b0;
        set_ctl(0, 0, 0, 0);
        @(negedge clk);
        chk("to_idle_pcw", if_a.hcu_pc_write, 1);
        chk("to_idle_flag", if_a.hcu_timeout, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
